// File: rtl/pwm_multi.sv
// pwm_multi: N-channel complementary PWM generator with edge/center counting,
// per-channel dead-time, boundary-synchronous shadow registers and a period-start strobe.
module pwm_multi #(
   parameter int N_CH  = 2,
   parameter int CNT_W = 14,
   parameter int DT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  center_mode,
   input  logic [CNT_W-1:0]      period_in,
   input  logic [N_CH*CNT_W-1:0] duty_in,
   input  logic [DT_W-1:0]       deadtime_in,
   input  logic                  cfg_wr,
   output logic [N_CH-1:0]       pwm_hi,
   output logic [N_CH-1:0]       pwm_lo,
   output logic                  period_start,
   output logic [CNT_W-1:0]      cnt
);

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_LO   = 3'd1,
      ST_DT_H = 3'd2,
      ST_HI   = 3'd3,
      ST_DT_L = 3'd4
   } ch_state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DT_W-1:0]  DT_ZERO  = {DT_W{1'b0}};
   localparam logic [DT_W-1:0]  DT_ONE   = {{(DT_W-1){1'b0}}, 1'b1};

   // True once the dead-time counter has covered 'dt' cycles; '>=' keeps a
   // mid-gap reduction of dt from stranding the channel in a gap state.
   function automatic logic dt_done(input logic [DT_W-1:0] dtc, input logic [DT_W-1:0] dt);
      logic [DT_W:0] nxt;
      nxt = {1'b0, dtc} + {{DT_W{1'b0}}, 1'b1};
      return (nxt >= {1'b0, dt});
   endfunction

   logic [CNT_W-1:0]      stg_period_r, shd_period_r, eff_period_s;
   logic [N_CH*CNT_W-1:0] stg_duty_r, shd_duty_r, eff_duty_s;
   logic [DT_W-1:0]       stg_dt_r, shd_dt_r, eff_dt_s;
   logic                  stg_center_r, shd_center_r, eff_center_s;
   logic                  pend_r, boundary_s, run_ok_s;
   logic [CNT_W-1:0]      cnt_r, cnt_s;
   logic                  dir_r, dir_s;
   logic [N_CH-1:0]       raw_s, hi_r, lo_r;
   ch_state_t             enter_hi_s, enter_lo_s;
   ch_state_t             st_r  [N_CH];
   ch_state_t             st_s  [N_CH];
   logic [DT_W-1:0]       dtc_r [N_CH];
   logic [DT_W-1:0]       dtc_s [N_CH];

   // Boundary detection; on a boundary cycle the staged values already govern the logic.
   // pend_r lets a fresh cfg_wr (or reset) produce a boundary while the period is 0.
   always_comb begin
      boundary_s = en && (cnt_r == CNT_ZERO) && ((shd_period_r != CNT_ZERO) || pend_r);
      if (boundary_s) begin
         eff_period_s = stg_period_r;
         eff_duty_s   = stg_duty_r;
         eff_dt_s     = stg_dt_r;
         eff_center_s = stg_center_r;
      end else begin
         eff_period_s = shd_period_r;
         eff_duty_s   = shd_duty_r;
         eff_dt_s     = shd_dt_r;
         eff_center_s = shd_center_r;
      end
      run_ok_s = en && (eff_period_s != CNT_ZERO);
   end

   // Staging registers capture host configuration on cfg_wr.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_period_r <= CNT_ZERO;
         stg_duty_r   <= {(N_CH*CNT_W){1'b0}};
         stg_dt_r     <= DT_ZERO;
         stg_center_r <= 1'b0;
      end else if (cfg_wr) begin
         stg_period_r <= period_in;
         stg_duty_r   <= duty_in;
         stg_dt_r     <= deadtime_in;
         stg_center_r <= center_mode;
      end
   end

   // Shadow registers load from staging only at a boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         shd_period_r <= CNT_ZERO;
         shd_duty_r   <= {(N_CH*CNT_W){1'b0}};
         shd_dt_r     <= DT_ZERO;
         shd_center_r <= 1'b0;
         pend_r       <= 1'b1;
      end else begin
         if (boundary_s) begin
            shd_period_r <= stg_period_r;
            shd_duty_r   <= stg_duty_r;
            shd_dt_r     <= stg_dt_r;
            shd_center_r <= stg_center_r;
         end
         pend_r <= boundary_s ? cfg_wr : (pend_r | cfg_wr);
      end
   end

   // Counter next value; a boundary always restarts the count upward (dir 0 = up).
   always_comb begin
      cnt_s = cnt_r;
      dir_s = dir_r;
      if (!en) begin
         cnt_s = cnt_r;
         dir_s = dir_r;
      end else if (eff_period_s == CNT_ZERO) begin
         cnt_s = CNT_ZERO;
         dir_s = 1'b0;
      end else if (!eff_center_s) begin
         cnt_s = (cnt_r == (eff_period_s - CNT_ONE)) ? CNT_ZERO : (cnt_r + CNT_ONE);
         dir_s = 1'b0;
      end else if (boundary_s || !dir_r) begin
         if (cnt_r == eff_period_s) begin
            cnt_s = cnt_r - CNT_ONE;
            dir_s = 1'b1;
         end else begin
            cnt_s = cnt_r + CNT_ONE;
            dir_s = 1'b0;
         end
      end else begin
         cnt_s = cnt_r - CNT_ONE;
         dir_s = 1'b1;
      end
   end

   // Counter and direction registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= CNT_ZERO;
         dir_r <= 1'b0;
      end else begin
         cnt_r <= cnt_s;
         dir_r <= dir_s;
      end
   end

   // Raw compare; D >= P pins the channel high even at the center-mode top count.
   always_comb begin
      raw_s = {N_CH{1'b0}};
      for (int i = 0; i < N_CH; i++) begin
         raw_s[i] = (eff_duty_s[i*CNT_W +: CNT_W] >= eff_period_s) ||
                    (cnt_r < eff_duty_s[i*CNT_W +: CNT_W]);
      end
      enter_hi_s = (eff_dt_s == DT_ZERO) ? ST_HI : ST_DT_H;
      enter_lo_s = (eff_dt_s == DT_ZERO) ? ST_LO : ST_DT_L;
   end

   // Per-channel gate FSM next state.
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         st_s[i]  = st_r[i];
         dtc_s[i] = DT_ZERO;
         if (!run_ok_s) begin
            st_s[i] = ST_OFF;
         end else begin
            case (st_r[i])
               ST_OFF:  st_s[i] = raw_s[i] ? enter_hi_s : enter_lo_s;
               ST_DT_H: begin
                  if (!raw_s[i]) begin
                     st_s[i] = ST_LO;
                  end else if (dt_done(dtc_r[i], eff_dt_s)) begin
                     st_s[i] = ST_HI;
                  end else begin
                     st_s[i]  = ST_DT_H;
                     dtc_s[i] = dtc_r[i] + DT_ONE;
                  end
               end
               ST_HI:   st_s[i] = raw_s[i] ? ST_HI : enter_lo_s;
               ST_LO:   st_s[i] = raw_s[i] ? enter_hi_s : ST_LO;
               ST_DT_L: begin
                  if (raw_s[i]) begin
                     st_s[i] = ST_HI;
                  end else if (dt_done(dtc_r[i], eff_dt_s)) begin
                     st_s[i] = ST_LO;
                  end else begin
                     st_s[i]  = ST_DT_L;
                     dtc_s[i] = dtc_r[i] + DT_ONE;
                  end
               end
               default: st_s[i] = ST_OFF;
            endcase
         end
      end
   end

   // Channel state, dead-time counters and registered gate outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            st_r[i]  <= ST_OFF;
            dtc_r[i] <= DT_ZERO;
         end
         hi_r <= {N_CH{1'b0}};
         lo_r <= {N_CH{1'b0}};
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            st_r[i]  <= st_s[i];
            dtc_r[i] <= dtc_s[i];
            hi_r[i]  <= (st_s[i] == ST_HI);
            lo_r[i]  <= (st_s[i] == ST_LO);
         end
      end
   end

   assign pwm_hi       = hi_r;
   assign pwm_lo       = lo_r;
   assign cnt          = cnt_r;
   assign period_start = boundary_s & ~rst;

endmodule
